wbdma_sched: RTL and testbench

//  Round-robin scheduler that shares one wbdmac among NREQ requesters.

---
 rtl/wbdma_sched.sv | 279 +++++++++++++++++++++++++++
 tb/tb_wbdma_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbdma_sched.sv
// wbdma_sched: round-robin scheduler sharing one wbdmac among NREQ requesters.
// Captures the winning requester's descriptor, programs the DMAC control slave
// (len, src, dst, ctl) over a pipelined Wishbone master, waits for the DMAC
// interrupt (with watchdog), reads status and reports done/err to the owner.
//
// Ports:
//   i_clk, i_reset_n           clock, async active-low reset
//   i_req                      level requests, one bit per requester
//   i_req_len/src/dst/cfg      packed per-requester descriptors
//   o_grant                    one-hot pulse while in ARB: descriptor captured
//   o_done, o_err              one-hot completion pulse, error flag alongside
//   o_busy                     scheduler not idle
//   o_dwb_*                    WB master to DMAC control port
//   i_dwb_ack/stall/err/data   WB slave responses
//   i_dma_int                  DMAC completion/error interrupt
module wbdma_sched #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned AW        = 30,
    parameter int unsigned LGTIMEOUT = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*AW-1:0]   i_req_len,
    input  logic [NREQ*32-1:0]   i_req_src,
    input  logic [NREQ*32-1:0]   i_req_dst,
    input  logic [NREQ*18-1:0]   i_req_cfg,
    output logic [NREQ-1:0]      o_grant,
    output logic [NREQ-1:0]      o_done,
    output logic                 o_err,
    output logic                 o_busy,
    output logic                 o_dwb_cyc,
    output logic                 o_dwb_stb,
    output logic                 o_dwb_we,
    output logic [1:0]           o_dwb_addr,
    output logic [31:0]          o_dwb_data,
    input  logic                 i_dwb_ack,
    input  logic                 i_dwb_stall,
    input  logic                 i_dwb_err,
    input  logic [31:0]          i_dwb_data,
    input  logic                 i_dma_int
);

    localparam int unsigned LGN   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW    = (LGTIMEOUT > 0) ? LGTIMEOUT : 1;
    localparam bit          TO_EN = (LGTIMEOUT > 0);

    localparam logic [1:0]  A_CTL = 2'd0;
    localparam logic [1:0]  A_LEN = 2'd1;
    localparam logic [1:0]  A_SRC = 2'd2;
    localparam logic [1:0]  A_DST = 2'd3;
    localparam logic [31:0] ABORT_WORD = 32'hffed_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_WR_LEN, S_WR_SRC, S_WR_DST, S_WR_CTL,
        S_WAIT_INT, S_RD_STAT, S_ABORT, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [LGN-1:0]     r_rr, w_rr_nxt;
    logic [LGN-1:0]     r_owner;
    logic [AW-1:0]      r_len;
    logic [31:0]        r_src, r_dst;
    logic [17:0]        r_cfg;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [NREQ-1:0]    r_grant, w_grant_nxt;
    logic [NREQ-1:0]    r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic               r_busy;
    logic               r_cyc, w_cyc_nxt;
    logic               r_stb, w_stb_nxt;
    logic               r_we, w_we_nxt;
    logic [1:0]         r_addr, w_addr_nxt;
    logic [31:0]        r_data, w_data_nxt;
    logic               w_cap;

    logic [LGN-1:0]     w_idx [NREQ];
    logic [LGN-1:0]     w_win;
    logic [AW-1:0]      w_sel_len;
    logic [31:0]        w_sel_src, w_sel_dst;
    logic [17:0]        w_sel_cfg;
    logic [NREQ-1:0]    w_owner_oh;
    logic [31:0]        w_ctl_word;
    logic               w_unused_stat;

    // Only the two DMAC error flags of the status word matter here.
    assign w_unused_stat = ^i_dwb_data[29:0];

    assign w_owner_oh = NREQ'(1) << r_owner;
    assign w_ctl_word = {2'b00, r_cfg[17], r_cfg[16], 12'hfed, r_cfg[15:0]};

    // Search order starting at the round-robin pointer, wrapping.
    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx[k] = LGN'((32'(r_rr) + k) % NREQ);
        end
    end

    // Winner = first asserted request at/after the pointer; mux its descriptor.
    always_comb begin
        w_win     = '0;
        w_sel_len = '0;
        w_sel_src = '0;
        w_sel_dst = '0;
        w_sel_cfg = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[w_idx[k]]) w_win = w_idx[k];
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_win == LGN'(k)) begin
                w_sel_len = i_req_len[k*AW +: AW];
                w_sel_src = i_req_src[k*32 +: 32];
                w_sel_dst = i_req_dst[k*32 +: 32];
                w_sel_cfg = i_req_cfg[k*18 +: 18];
            end
        end
    end

    // Next-state and next-output logic; every output is registered so each
    // output value lines up with the state it belongs to.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_cnt_nxt   = '0;
        w_grant_nxt = '0;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_cyc_nxt   = r_cyc;
        w_stb_nxt   = r_stb;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_cap       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_cap       = 1'b1;
                    w_grant_nxt = NREQ'(1) << w_win;
                    w_state_nxt = S_ARB;
                end
            end

            S_ARB: begin
                if (r_len == '0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = w_owner_oh;
                end else begin
                    w_state_nxt = S_WR_LEN;
                end
            end

            // One WB transaction per state; a new one starts only after cyc
            // has been low for a clock.
            S_WR_LEN, S_WR_SRC, S_WR_DST, S_WR_CTL, S_RD_STAT, S_ABORT: begin
                if (!r_cyc) begin
                    w_cyc_nxt = 1'b1;
                    w_stb_nxt = 1'b1;
                    w_we_nxt  = (r_state != S_RD_STAT);
                    case (r_state)
                        S_WR_LEN: begin w_addr_nxt = A_LEN; w_data_nxt = 32'(r_len); end
                        S_WR_SRC: begin w_addr_nxt = A_SRC; w_data_nxt = r_src;      end
                        S_WR_DST: begin w_addr_nxt = A_DST; w_data_nxt = r_dst;      end
                        S_WR_CTL: begin w_addr_nxt = A_CTL; w_data_nxt = w_ctl_word; end
                        S_ABORT:  begin w_addr_nxt = A_CTL; w_data_nxt = ABORT_WORD; end
                        default:  begin w_addr_nxt = A_CTL; w_data_nxt = '0;         end
                    endcase
                end else if (i_dwb_err) begin
                    w_cyc_nxt   = 1'b0;
                    w_stb_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_state_nxt = S_DONE;
                    w_done_nxt  = w_owner_oh;
                    w_err_nxt   = 1'b1;
                end else begin
                    if (r_stb && !i_dwb_stall) w_stb_nxt = 1'b0;
                    if (i_dwb_ack) begin
                        w_cyc_nxt = 1'b0;
                        w_stb_nxt = 1'b0;
                        w_we_nxt  = 1'b0;
                        case (r_state)
                            S_WR_LEN: w_state_nxt = S_WR_SRC;
                            S_WR_SRC: w_state_nxt = S_WR_DST;
                            S_WR_DST: w_state_nxt = S_WR_CTL;
                            S_WR_CTL: w_state_nxt = S_WAIT_INT;
                            S_RD_STAT: begin
                                w_state_nxt = S_DONE;
                                w_done_nxt  = w_owner_oh;
                                w_err_nxt   = i_dwb_data[30] | i_dwb_data[31];
                            end
                            S_ABORT: begin
                                w_state_nxt = S_DONE;
                                w_done_nxt  = w_owner_oh;
                                w_err_nxt   = 1'b1;
                            end
                            default: w_state_nxt = S_IDLE;
                        endcase
                    end
                end
            end

            // Watchdog counts from zero on entry; the interrupt wins a tie.
            S_WAIT_INT: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (i_dma_int) begin
                    w_state_nxt = S_RD_STAT;
                end else if (TO_EN && (r_cnt == {CW{1'b1}})) begin
                    w_state_nxt = S_ABORT;
                end
            end

            S_DONE: begin
                w_rr_nxt    = (r_owner == LGN'(NREQ - 1)) ? '0 : r_owner + LGN'(1);
                w_state_nxt = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_cyc   <= w_cyc_nxt;
            r_stb   <= w_stb_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Descriptor and owner capture at arbitration.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_owner <= '0;
            r_len   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_cfg   <= '0;
        end else if (w_cap) begin
            r_owner <= w_win;
            r_len   <= w_sel_len;
            r_src   <= w_sel_src;
            r_dst   <= w_sel_dst;
            r_cfg   <= w_sel_cfg;
        end
    end

    assign o_grant    = r_grant;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_busy     = r_busy;
    assign o_dwb_cyc  = r_cyc;
    assign o_dwb_stb  = r_stb;
    assign o_dwb_we   = r_we;
    assign o_dwb_addr = r_addr;
    assign o_dwb_data = r_data;

endmodule

// File: tb/tb_wbdma_sched.sv
// Bench for wbdma_sched: directed scenarios plus a randomized run, checked
// against a transaction-level model (round-robin pick, expected register
// write list, expected error outcome) and a behavioural DMAC slave.
module tb_wbdma_sched;

    localparam int NREQ = 4;
    localparam int AW   = 30;
    localparam int LGT  = 6;

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
    } bus_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_len;
    logic [NREQ*32-1:0]  req_src, req_dst;
    logic [NREQ*18-1:0]  req_cfg;
    logic [NREQ-1:0]     o_grant, o_done;
    logic                o_err, o_busy, o_dwb_cyc, o_dwb_stb, o_dwb_we;
    logic [1:0]          o_dwb_addr;
    logic [31:0]         o_dwb_data;
    logic                i_dwb_ack, i_dwb_stall, i_dwb_err, i_dma_int;
    logic [31:0]         i_dwb_data;

    always #5 clk = ~clk;

    wbdma_sched #(.NREQ(NREQ), .AW(AW), .LGTIMEOUT(LGT)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req(req), .i_req_len(req_len), .i_req_src(req_src),
        .i_req_dst(req_dst), .i_req_cfg(req_cfg),
        .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
        .o_dwb_cyc(o_dwb_cyc), .o_dwb_stb(o_dwb_stb), .o_dwb_we(o_dwb_we),
        .o_dwb_addr(o_dwb_addr), .o_dwb_data(o_dwb_data),
        .i_dwb_ack(i_dwb_ack), .i_dwb_stall(i_dwb_stall), .i_dwb_err(i_dwb_err),
        .i_dwb_data(i_dwb_data), .i_dma_int(i_dma_int)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: round-robin pointer and requester descriptors.
    int              m_rr = 0;
    logic [AW-1:0]   d_len [NREQ];
    logic [31:0]     d_src [NREQ];
    logic [31:0]     d_dst [NREQ];
    logic [17:0]     d_cfg [NREQ];

    // DMAC slave configuration and observations.
    bit          int_en = 1'b1;
    int          int_dly = 0;
    logic [31:0] stat_val = 32'h0;
    int          err_addr = -1;
    int          stall_addr = -1;
    int          stall_left = 0;
    bit          rnd_stall = 1'b0;
    int          cyc_now = 0;
    int          t_ctl_ack = -1;
    int          t_abort = -1;
    int          stb_cnt2 = 0;
    int          cyc_seen = 0;
    int          gap_viol = 0;
    bus_t        log_q [$];
    bus_t        exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural DMAC control slave: optional stalls, 0..2 clock ack latency,
    // injected bus error, interrupt some clocks after the control write.
    task automatic slave();
        bit   pend = 0, perr = 0, prd = 0, pctl = 0, drop_chk = 0, armed = 0;
        int   dly = 0, icnt = 0;
        bus_t e;
        forever begin
            @(negedge clk);
            cyc_now++;
            if (o_dwb_cyc) cyc_seen++;
            if (drop_chk) begin
                if (o_dwb_cyc) gap_viol++;
                drop_chk = 0;
            end
            i_dwb_ack = 1'b0; i_dwb_err = 1'b0; i_dwb_stall = 1'b0; i_dma_int = 1'b0;
            if (!rst_n) begin
                pend = 0; armed = 0;
                continue;
            end
            if (armed) begin
                if (icnt == 0) begin i_dma_int = 1'b1; armed = 0; end
                else icnt--;
            end
            if (o_dwb_cyc && o_dwb_stb && o_dwb_addr == 2'd2) stb_cnt2++;
            if (pend) begin
                if (dly == 0) begin
                    pend = 0;
                    drop_chk = 1;
                    if (perr) i_dwb_err = 1'b1;
                    else begin
                        i_dwb_ack  = 1'b1;
                        i_dwb_data = prd ? stat_val : 32'h0;
                        if (pctl) begin
                            t_ctl_ack = cyc_now;
                            if (int_en) begin armed = 1; icnt = int_dly; end
                        end
                    end
                end else dly--;
            end else if (o_dwb_cyc && o_dwb_stb) begin
                if (int'(o_dwb_addr) == stall_addr && stall_left > 0) begin
                    i_dwb_stall = 1'b1;
                    stall_left--;
                end else if (rnd_stall && $urandom_range(0, 2) == 0) begin
                    i_dwb_stall = 1'b1;
                end else begin
                    e.we   = o_dwb_we;
                    e.addr = o_dwb_addr;
                    e.data = o_dwb_we ? o_dwb_data : 32'h0;
                    log_q.push_back(e);
                    pend = 1;
                    dly  = $urandom_range(0, 2);
                    perr = o_dwb_we && int'(o_dwb_addr) == err_addr;
                    prd  = !o_dwb_we;
                    pctl = o_dwb_we && o_dwb_addr == 2'd0 && o_dwb_data != 32'hffed0000;
                    if (o_dwb_we && o_dwb_addr == 2'd0 && !pctl) t_abort = cyc_now;
                end
            end
        end
    endtask

    function automatic int model_winner(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [AW-1:0] len, input logic [31:0] src,
                           input logic [31:0] dst, input logic [17:0] cfg);
        d_len[k] = len; d_src[k] = src; d_dst[k] = dst; d_cfg[k] = cfg;
        req_len[k*AW +: AW] = len;
        req_src[k*32 +: 32] = src;
        req_dst[k*32 +: 32] = dst;
        req_cfg[k*18 +: 18] = cfg;
        req[k] = 1'b1;
    endtask

    task automatic push_exp(input logic we, input logic [1:0] a, input logic [31:0] d);
        bus_t e;
        e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // One arbitration + transfer; expectation built from the current request
    // set and slave configuration.
    task automatic do_txn(input bit hold, output int owner);
        int   w, t;
        bit   exp_err, stop;
        logic [31:0] ctl;
        log_q.delete(); exp_q.delete();
        cyc_seen = 0; t_ctl_ack = -1; t_abort = -1; stb_cnt2 = 0;
        w = model_winner(req);
        owner = w;
        if (w < 0) begin
            check("no_request", 64'(req), 64'(1));
            return;
        end
        exp_err = 1'b0;
        stop = 1'b0;
        if (d_len[w] != '0) begin
            ctl = (32'(d_cfg[w][17]) << 29) | (32'(d_cfg[w][16]) << 28) |
                  (32'hfed << 16) | 32'(d_cfg[w][15:0]);
            push_exp(1'b1, 2'd1, 32'(d_len[w]));
            if (err_addr == 1) stop = 1'b1;
            if (!stop) begin push_exp(1'b1, 2'd2, d_src[w]); if (err_addr == 2) stop = 1'b1; end
            if (!stop) begin push_exp(1'b1, 2'd3, d_dst[w]); if (err_addr == 3) stop = 1'b1; end
            if (!stop) begin push_exp(1'b1, 2'd0, ctl);      if (err_addr == 0) stop = 1'b1; end
            if (stop) exp_err = 1'b1;
            else if (int_en) begin
                push_exp(1'b0, 2'd0, 32'h0);
                exp_err = stat_val[30] | stat_val[31];
            end else begin
                push_exp(1'b1, 2'd0, 32'hffed0000);
                exp_err = 1'b1;
            end
        end
        t = 0;
        do begin @(negedge clk); t++; end while (o_grant == '0 && t < 50);
        check("grant", 64'(o_grant), 64'(4'b1 << w));
        if (!hold) req[w] = 1'b0;
        t = 0;
        while (o_done == '0 && t < 400) begin @(negedge clk); t++; end
        check("done_vec", 64'(o_done), 64'(4'b1 << w));
        check("done_err", 64'(o_err), 64'(exp_err));
        if (d_len[w] == '0) begin
            check("len0_latency", 64'(t <= 3), 64'(1));
            check("len0_no_cyc", 64'(cyc_seen), 64'(0));
        end
        check("bus_count", 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("bus_op%0d", i), 64'(log_q[i]), 64'(exp_q[i]));
        end
        @(negedge clk);
        check("done_pulse_end", 64'({o_done, o_err}), 64'(0));
        m_rr = (w + 1) % NREQ;
    endtask

    initial begin
        int own, t;
        rst_n = 1'b0;
        req = '0; req_len = '0; req_src = '0; req_dst = '0; req_cfg = '0;
        i_dwb_ack = 1'b0; i_dwb_stall = 1'b0; i_dwb_err = 1'b0;
        i_dwb_data = 32'h0; i_dma_int = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            d_len[k] = '0; d_src[k] = '0; d_dst[k] = '0; d_cfg[k] = '0;
        end
        fork slave(); join_none
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({o_grant, o_done, o_err, o_busy, o_dwb_cyc, o_dwb_stb,
                                    o_dwb_we, o_dwb_addr, o_dwb_data}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_not_busy", 64'(o_busy), 64'(0));

        // Basic transfer, status clean.
        set_req(0, 30'd16, 32'h1000, 32'h2000, 18'h0);
        int_dly = 3; stat_val = 32'h0;
        do_txn(1'b0, own);

        // Zero length: grant then done, no bus traffic.
        set_req(2, 30'd0, 32'hdead, 32'hbeef, 18'h3ffff);
        do_txn(1'b0, own);

        // Status with error flag.
        set_req(1, 30'd5, 32'habc0, 32'hdef0, 18'h2a5a5);
        stat_val = 32'h4000_0000;
        do_txn(1'b0, own);
        stat_val = 32'h0;

        // Watchdog abort when no interrupt arrives.
        set_req(3, 30'd100, 32'h10, 32'h20, 18'h1_8123);
        int_en = 1'b0;
        do_txn(1'b0, own);
        check("timeout_gap", 64'((t_abort - t_ctl_ack) >= 64 && (t_abort - t_ctl_ack) <= 70), 64'(1));
        int_en = 1'b1;

        // Stalled source write, bus error on destination write.
        set_req(0, 30'd7, 32'h3000, 32'h4000, 18'h0);
        stall_addr = 2; stall_left = 5; err_addr = 3;
        do_txn(1'b0, own);
        check("stall_stb_held", 64'(stb_cnt2), 64'(6));
        stall_addr = -1; err_addr = -1;

        // Reset while waiting for the interrupt.
        set_req(1, 30'd9, 32'h5000, 32'h6000, 18'h0);
        int_en = 1'b0;
        t_ctl_ack = -1;
        t = 0;
        do begin @(negedge clk); t++; end while (o_grant == '0 && t < 50);
        check("rst_case_grant", 64'(o_grant), 64'(4'b0010));
        req = '0;
        t = 0;
        while (t_ctl_ack < 0 && t < 100) begin @(negedge clk); t++; end
        check("rst_case_ctl_ack", 64'(t_ctl_ack >= 0), 64'(1));
        repeat (10) @(negedge clk);
        check("rst_case_busy", 64'(o_busy), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", 64'({o_grant, o_done, o_err, o_busy, o_dwb_cyc, o_dwb_stb,
                                      o_dwb_we, o_dwb_addr, o_dwb_data}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc_seen = 0; t = 0;
        repeat (100) begin @(negedge clk); if (o_done != '0) t++; end
        check("rst_no_done", 64'(t), 64'(0));
        check("rst_no_cyc", 64'(cyc_seen), 64'(0));
        m_rr = 0;
        int_en = 1'b1;

        // Held requests 0 and 1, then 3 joins mid-run.
        set_req(0, 30'd0, 32'h0, 32'h0, 18'h0);
        set_req(1, 30'd3, 32'h100, 32'h200, 18'h0);
        do_txn(1'b1, own); check("rr_order0", 64'(own), 64'(0));
        do_txn(1'b1, own); check("rr_order1", 64'(own), 64'(1));
        set_req(3, 30'd0, 32'h0, 32'h0, 18'h0);
        do_txn(1'b1, own); check("rr_order3", 64'(own), 64'(3));
        req[3] = 1'b0;
        do_txn(1'b1, own); check("rr_order0b", 64'(own), 64'(0));
        do_txn(1'b1, own); check("rr_order1b", 64'(own), 64'(1));
        req = '0;
        repeat (3) @(negedge clk);

        // Randomized transfers.
        rnd_stall = 1'b1;
        for (int it = 0; it < 14; it++) begin
            logic [NREQ-1:0] nr;
            nr = NREQ'($urandom_range(1, 15));
            for (int k = 0; k < NREQ; k++) begin
                if (nr[k] && !req[k]) begin
                    set_req(k, ($urandom_range(0, 3) == 0) ? 30'd0 : 30'($urandom_range(1, 1000)),
                            $urandom, $urandom, 18'($urandom));
                end
            end
            int_en   = ($urandom_range(0, 7) != 0);
            int_dly  = $urandom_range(0, 5);
            stat_val = $urandom;
            err_addr = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            do_txn(1'(($urandom_range(0, 3) == 0)), own);
        end
        req = '0;
        err_addr = -1;
        repeat (5) @(negedge clk);
        check("cyc_gap_between_ops", 64'(gap_viol), 64'(0));
        check("final_idle", 64'(o_busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
